// File: rtl/simple_read_arbiter.sv
// Round-robin arbiter that lets N_REQ read requesters share one simple read port.
// A transfer runs from grant to the port's last beat and cannot be preempted.
module simple_read_arbiter #(
    parameter int N_REQ      = 2,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*AXI_ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*LEN_W-1:0]      req_len_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [AXI_DATA_W-1:0]       req_data_o,
    output logic [N_REQ-1:0]            req_last_o,
    output logic                        m_rvalid_o,
    output logic [AXI_ADDR_W-1:0]       m_raddr_o,
    output logic [LEN_W-1:0]            m_rlen_o,
    input  logic                        m_rready_i,
    input  logic [AXI_DATA_W-1:0]       m_rdata_i,
    input  logic                        m_rlast_i,
    output logic                        busy_o,
    output logic [2:0]                  grant_o,
    output logic [LEN_W-1:0]            beat_cnt_o
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                  state_q;
    logic [2:0]              grant_q;
    logic [2:0]              ptr_q;
    logic [LEN_W-1:0]        beat_cnt_q;

    logic                    busy;
    logic [2:0]              pick;
    logic [3:0]              off;
    logic [3:0]              best;
    logic                    sel_valid;
    logic [AXI_ADDR_W-1:0]   sel_addr;
    logic [LEN_W-1:0]        sel_len;
    logic [N_REQ-1:0]        onehot;

    assign busy = (state_q == BUSY);

    // Winner is the active requester with the smallest distance after the pointer.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pick = ptr_q;
        off  = '0;
        best = 4'hF;
        for (int k = 0; k < N_REQ; k++) begin
            if (3'(k) >= ptr_q) begin
                off = 4'(k) - 4'(ptr_q);
            end else begin
                off = 4'(k + N_REQ) - 4'(ptr_q);
            end
            if (req_valid_i[k] && (off < best)) begin
                best = off;
                pick = 3'(k);
            end
        end
    end

    // Address and length are routed live from the granted requester, never registered.
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        onehot    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_q == 3'(k)) begin
                sel_valid = req_valid_i[k];
                sel_addr  = req_addr_i[k*AXI_ADDR_W +: AXI_ADDR_W];
                sel_len   = req_len_i[k*LEN_W +: LEN_W];
                onehot[k] = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid_i) begin
                        grant_q    <= pick;
                        beat_cnt_q <= '0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (m_rready_i && (beat_cnt_q != '1)) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                    // Returning to IDLE forces a gap cycle with m_rvalid_o low.
                    if (m_rready_i && m_rlast_i) begin
                        state_q <= IDLE;
                        ptr_q   <= (grant_q == 3'(N_REQ-1)) ? 3'd0 : grant_q + 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = busy;
    assign grant_o     = grant_q;
    assign beat_cnt_o  = beat_cnt_q;
    assign req_data_o  = m_rdata_i;
    assign m_rvalid_o  = busy & sel_valid;
    assign m_raddr_o   = busy ? sel_addr : '0;
    assign m_rlen_o    = busy ? sel_len : '0;
    assign req_ready_o = (busy && m_rready_i) ? onehot : '0;
    assign req_last_o  = (busy && m_rready_i && m_rlast_i) ? onehot : '0;

endmodule

// File: tb/tb_simple_read_arbiter.sv
// Self-checking bench for simple_read_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_simple_read_arbiter;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LW  = 8;
    localparam int SN  = 3;
    localparam int SLW = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    // Main instance (defaults)
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   req_data;
    logic [N-1:0]    req_last;
    logic            m_rvalid;
    logic [AW-1:0]   m_raddr;
    logic [LW-1:0]   m_rlen;
    logic            m_rready;
    logic [DW-1:0]   m_rdata;
    logic            m_rlast;
    logic            busy;
    logic [2:0]      grant;
    logic [LW-1:0]   beat_cnt;

    // Second instance: three requesters, narrow counter
    logic [SN-1:0]     s_valid;
    logic [SN*AW-1:0]  s_addr;
    logic [SN*SLW-1:0] s_len;
    logic [SN-1:0]     s_ready;
    logic [DW-1:0]     s_data;
    logic [SN-1:0]     s_last;
    logic              s_rvalid;
    logic [AW-1:0]     s_raddr;
    logic [SLW-1:0]    s_rlen;
    logic              s_rready;
    logic [DW-1:0]     s_rdata;
    logic              s_rlast;
    logic              s_busy;
    logic [2:0]        s_grant;
    logic [SLW-1:0]    s_cnt;

    simple_read_arbiter #(.N_REQ(N), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_len_i(req_len),
        .req_ready_o(req_ready), .req_data_o(req_data), .req_last_o(req_last),
        .m_rvalid_o(m_rvalid), .m_raddr_o(m_raddr), .m_rlen_o(m_rlen),
        .m_rready_i(m_rready), .m_rdata_i(m_rdata), .m_rlast_i(m_rlast),
        .busy_o(busy), .grant_o(grant), .beat_cnt_o(beat_cnt)
    );

    simple_read_arbiter #(.N_REQ(SN), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(SLW)) u_sat (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(s_valid), .req_addr_i(s_addr), .req_len_i(s_len),
        .req_ready_o(s_ready), .req_data_o(s_data), .req_last_o(s_last),
        .m_rvalid_o(s_rvalid), .m_raddr_o(s_raddr), .m_rlen_o(s_rlen),
        .m_rready_i(s_rready), .m_rdata_i(s_rdata), .m_rlast_i(s_rlast),
        .busy_o(s_busy), .grant_o(s_grant), .beat_cnt_o(s_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: in-flight flag, granted index, round-robin pointer, beat count.
    int mb, mg, mp, mc;

    task automatic model_reset();
        mb = 0; mg = 0; mp = 0; mc = 0;
    endtask

    function automatic int rr_pick();
        for (int o = 0; o < N; o++) begin
            if (req_valid[(mp + o) % N]) return (mp + o) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        int k;
        if (mb == 0) begin
            k = rr_pick();
            if (k >= 0) begin
                mb = 1; mg = k; mc = 0;
            end
        end else begin
            if (m_rready) mc = (mc + 1 > (1 << LW) - 1) ? (1 << LW) - 1 : mc + 1;
            if (m_rready && m_rlast) begin
                mb = 0;
                mp = (mg + 1) % N;
            end
        end
    endtask

    task automatic model_compare();
        logic [63:0] exp_rdy, exp_last;
        exp_rdy  = (mb != 0 && m_rready) ? (64'd1 << mg) : 64'd0;
        exp_last = (mb != 0 && m_rready && m_rlast) ? (64'd1 << mg) : 64'd0;
        check("busy", busy, (mb != 0));
        if (mb != 0) check("grant", grant, mg);
        check("m_rvalid", m_rvalid, (mb != 0) ? req_valid[mg] : 1'b0);
        check("m_raddr", m_raddr, (mb != 0) ? req_addr[mg*AW +: AW] : '0);
        check("m_rlen", m_rlen, (mb != 0) ? req_len[mg*LW +: LW] : '0);
        check("req_ready", req_ready, exp_rdy);
        check("req_last", req_last, exp_last);
        check("beat_cnt", beat_cnt, mc);
        check("req_data", req_data, m_rdata);
    endtask

    task automatic sample();
        @(negedge clk_i);
        model_compare();
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0; req_addr = '0; req_len = '0;
        m_rready = 1'b0; m_rlast = 1'b0; m_rdata = '0;
        s_valid = '0; s_addr = '0; s_len = '0;
        s_rready = 1'b0; s_rlast = 1'b0; s_rdata = '0;
        rst_ni = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_rvalid", m_rvalid, 1'b0);
        check("rst_grant", grant, 3'd0);
        check("rst_cnt", beat_cnt, '0);
        model_reset();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    // Delivers beats to the current transfer, with random idle gaps; optionally drops a request after last.
    task automatic serve(input int beats, input int drop, output int pulses);
        pulses = 0;
        for (int b = 0; b < beats; b++) begin
            if ($urandom_range(0, 2) == 0) begin
                m_rready = 1'b0; m_rlast = 1'($urandom_range(0, 1)); m_rdata = $urandom;
                sample(); tick();
            end
            m_rready = 1'b1; m_rlast = (b == beats - 1); m_rdata = $urandom;
            sample();
            if (req_ready != '0) pulses++;
            if (b == beats - 1) check("last_on_final_beat", (req_last != '0), 1'b1);
            tick();
        end
        m_rready = 1'b0; m_rlast = 1'b0;
        if (drop >= 0) req_valid[drop] = 1'b0;
    endtask

    task automatic wait_busy(input string tag, output int g);
        bit found;
        found = 0;
        g = -1;
        for (int c = 0; c < 8 && !found; c++) begin
            sample();
            if (busy) begin
                found = 1;
                g = int'(grant);
            end
            tick();
        end
        if (!found) check({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p, g, sg;
        bit found;
        int exp_seq [4] = '{0, 1, 2, 0};

        // Single requester, 4-beat response
        do_reset();
        req_addr[0 +: AW] = 32'h100; req_len[0 +: LW] = 8'd16; req_valid = 2'b01;
        sample(); check("t1_arb_latency", m_rvalid, 1'b0); tick();
        sample();
        check("t1_rvalid", m_rvalid, 1'b1);
        check("t1_raddr", m_raddr, 32'h100);
        check("t1_rlen", m_rlen, 8'd16);
        tick();
        serve(4, 0, p);
        check("t1_pulses", p, 4);
        sample(); check("t1_cnt", beat_cnt, 4); check("t1_idle", busy, 1'b0); tick();

        // Spurious beats while idle: nothing moves
        for (int i = 0; i < 3; i++) begin
            m_rready = 1'b1; m_rlast = 1'b1;
            sample();
            check("spur_ready", req_ready, '0);
            check("spur_last", req_last, '0);
            check("spur_busy", busy, 1'b0);
            check("spur_cnt", beat_cnt, 4);
            tick();
        end
        m_rready = 1'b0; m_rlast = 1'b0;

        // Simultaneous requests
        do_reset();
        req_addr = {32'h300, 32'h200}; req_len = {8'd12, 8'd8}; req_valid = 2'b11;
        sample(); tick();
        sample(); check("t2_first_grant", grant, 0); tick();
        serve(3, 0, p);
        sample(); check("t2_gap_busy", busy, 1'b0); check("t2_gap_rvalid", m_rvalid, 1'b0); tick();
        sample(); check("t2_second_grant", grant, 1); check("t2_raddr1", m_raddr, 32'h300); tick();
        serve(2, 1, p);
        req_valid = 2'b11;
        sample(); tick();
        sample(); check("t2_ptr_back_to_0", grant, 0); tick();
        serve(1, 0, p);
        req_valid = '0;

        // Fairness with both requesters permanently active
        do_reset();
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_busy("t3", g);
            check($sformatf("t3_grant_%0d", t), g, t % 2);
            serve($urandom_range(1, 3), -1, p);
        end
        req_valid = '0;

        // Reset mid-transfer
        do_reset();
        req_addr[0 +: AW] = 32'h400; req_len[0 +: LW] = 8'd16; req_valid = 2'b01;
        sample(); tick();
        sample(); tick();
        for (int b = 0; b < 2; b++) begin
            m_rready = 1'b1; m_rlast = 1'b0;
            sample(); tick();
        end
        #2 rst_ni = 1'b0;
        #1;
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_rvalid", m_rvalid, 1'b0);
        check("t4_rst_ready", req_ready, '0);
        check("t4_rst_last", req_last, '0);
        check("t4_rst_cnt", beat_cnt, '0);
        check("t4_rst_raddr", m_raddr, '0);
        model_reset();
        m_rready = 1'b0; req_valid = '0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        req_addr[AW +: AW] = 32'h500; req_len[LW +: LW] = 8'd8; req_valid = 2'b10;
        sample(); tick();
        sample(); check("t4_grant1", grant, 1); check("t4_cnt0", beat_cnt, 0); tick();
        serve(2, 1, p);
        sample(); check("t4_cnt2", beat_cnt, 2); tick();

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k]) begin
                    if ($urandom_range(0, 2) == 0 && !(mb != 0 && mg == k)) begin
                        req_addr[k*AW +: AW] = $urandom;
                        req_len[k*LW +: LW]  = LW'($urandom);
                        req_valid[k] = 1'b1;
                    end
                end else if ($urandom_range(0, 11) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            m_rready = 1'($urandom_range(0, 1));
            m_rlast  = ($urandom_range(0, 3) == 0);
            m_rdata  = $urandom;
            sample(); tick();
        end

        // Counter saturation and 3-way round-robin on the narrow instance
        do_reset();
        s_addr[2*AW +: AW] = 32'h700; s_len[2*SLW +: SLW] = 4'd9; s_valid = 3'b100;
        @(negedge clk_i); check("sat_idle", s_busy, 1'b0);
        @(posedge clk_i); #1;
        @(negedge clk_i); check("sat_busy", s_busy, 1'b1); check("sat_grant2", s_grant, 3'd2);
        @(posedge clk_i); #1;
        for (int b = 1; b <= 20; b++) begin
            s_rready = 1'b1; s_rlast = (b == 20);
            @(posedge clk_i); #1;
            check($sformatf("sat_cnt_%0d", b), s_cnt, (b > 15) ? 15 : b);
        end
        s_rready = 1'b0; s_rlast = 1'b0; s_valid = '0;
        @(negedge clk_i); check("sat_done_idle", s_busy, 1'b0); check("sat_hold", s_cnt, 4'd15);
        @(posedge clk_i); #1;

        s_valid = 3'b111;
        for (int t = 0; t < 4; t++) begin
            found = 0;
            sg = -1;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge clk_i);
                if (s_busy) begin
                    found = 1;
                    sg = int'(s_grant);
                end
                @(posedge clk_i); #1;
            end
            if (!found) check("rr3_timeout", 1'b0, 1'b1);
            check($sformatf("rr3_grant_%0d", t), sg, exp_seq[t]);
            s_rready = 1'b1; s_rlast = 1'b1;
            @(negedge clk_i); check($sformatf("rr3_last_%0d", t), s_last, 3'b001 << exp_seq[t]);
            @(posedge clk_i); #1;
            s_rready = 1'b0; s_rlast = 1'b0;
        end
        s_valid = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/simple_read_arbiter.md
SIMPLE_READ_ARBITER -- requirements
Module: simple_read_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- N_REQ, 2, number of requesters, 2..8
- AXI_ADDR_W, 32, address width
- AXI_DATA_W, 32, data width
- LEN_W, 8, byte-length width
REQ-002 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-003 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, clock
- rst_ni, in, 1, async active-low reset
- req_valid_i, in, N_REQ, per-requester read request
- req_addr_i, in, N_REQ*AXI_ADDR_W, flattened byte addresses; requester k at slice k
- req_len_i, in, N_REQ*LEN_W, flattened lengths in bytes
- req_ready_o, out, N_REQ, per-requester data-valid beat strobe
- req_data_o, out, AXI_DATA_W, read data broadcast to all requesters
- req_last_o, out, N_REQ, per-requester last-beat strobe
- m_rvalid_o, out, 1, request to the shared simple read port
- m_raddr_o, out, AXI_ADDR_W, muxed address
- m_rlen_o, out, LEN_W, muxed length
- m_rready_i, in, 1, data-valid beat from the shared port
- m_rdata_i, in, AXI_DATA_W, data from the shared port
- m_rlast_i, in, 1, last beat from the shared port
- busy_o, out, 1, transfer granted and in flight
- grant_o, out, 3, index of the granted requester, valid while busy_o
- beat_cnt_o, out, LEN_W, beats delivered in the current transfer

Function
REQ-004 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-005 In IDLE, when any req_valid_i bit is high, the block SHALL register grant as the first set bit at or after the round-robin pointer (wrapping modulo N_REQ) and enter BUSY on the next edge.
REQ-006 The block SHALL introduce 1 cycle of arbitration latency: m_rvalid_o SHALL be low in IDLE.
REQ-007 In BUSY, the block SHALL drive m_rvalid_o = req_valid_i[grant], m_raddr_o = req_addr_i[grant], and m_rlen_o = req_len_i[grant].
REQ-008 In IDLE, m_raddr_o and m_rlen_o SHALL be 0.
REQ-009 The block SHALL drive req_data_o = m_rdata_i combinationally at all times.
REQ-010 The block SHALL drive req_ready_o[grant] = m_rready_i and req_last_o[grant] = m_rready_i & m_rlast_i in BUSY; all other bits, and all bits in IDLE, SHALL be 0.
REQ-011 On m_rready_i & m_rlast_i in BUSY, the FSM SHALL return to IDLE and set the pointer to (grant+1) mod N_REQ.
REQ-012 The block SHALL guarantee at least one IDLE cycle between consecutive transfers, so the downstream port observes m_rvalid_o low before a new request.
REQ-013 beat_cnt_o SHALL clear on entry to BUSY and increment on each m_rready_i in BUSY.
REQ-014 beat_cnt_o SHALL saturate at all-ones.
REQ-015 beat_cnt_o SHALL hold its value in IDLE until the next grant.
REQ-016 Once granted, a transfer SHALL NOT be preempted.
REQ-017 A higher-index or newly arriving request SHALL wait for m_rlast_i.
REQ-018 If req_valid_i[grant] drops mid-transfer, the block SHALL stay in BUSY and keep routing beats until m_rlast_i.
REQ-019 The block SHALL ignore m_rready_i and m_rlast_i in IDLE: no strobes, no state change, no counter change.
REQ-020 Simultaneous request arrival SHALL be resolved by the round-robin pointer only.
REQ-021 Requests arriving in the same cycle as the m_rlast_i of the current transfer SHALL be considered in the following IDLE cycle.
REQ-022 Requesters SHALL hold address and length stable from assertion of req_valid_i until their req_last_o; the block SHALL NOT register them.

Reset
REQ-023 On rst_ni low, asynchronously, the block SHALL set state to IDLE, grant to 0, pointer to 0, and beat_cnt_o to 0.
REQ-024 During reset, busy_o, m_rvalid_o, req_ready_o and req_last_o SHALL be 0.
REQ-025 A reset mid-transfer SHALL abandon the transfer.
REQ-026 After reset release, the first grant SHALL go to the lowest-index active requester.
REQ-027 Deassertion of rst_ni SHALL be synchronous to clk_i by the integrator.

Verification
REQ-028 Single requester: req 0 issues addr 0x100, len 16, with AXI_DATA_W=32 and a 4-beat response; the bench SHALL check m_rvalid_o high 1 cycle after req_valid_i[0], req_ready_o[0] pulsed 4 times, req_last_o[0] on beat 4, and beat_cnt_o=4.
REQ-029 Simultaneous requests: req 0 and req 1 assert together after reset; the bench SHALL check that req 0 is served first, that req 1 is granted after 1 IDLE cycle, and that the pointer ends at 0.
REQ-030 Fairness: req 0 and req 1 both assert permanently, N_REQ=2; the bench SHALL check that grants alternate 0,1,0,1 over 4 transfers.
REQ-031 Spurious beats: m_rready_i=1 and m_rlast_i=1 pulsed while in IDLE; the bench SHALL check all req_ready_o and req_last_o are 0, the state is unchanged, and beat_cnt_o is unchanged.
REQ-032 Reset mid-transfer: rst_ni pulsed low after beat 2 of 4; the bench SHALL check that all outputs are 0 immediately (async) and that, after release, a new request to req 1 is granted with beat_cnt_o starting from 0.
REQ-033 Saturation: with LEN_W=4, the bench SHALL issue 20 beats before m_rlast_i and check that beat_cnt_o holds at 15.
